// File: rtl/ahb_burst_pkg.sv
// Shared encodings and burst-shape helpers for the AHB burst checker.
// Pure declarations; no clocked logic.
package ahb_burst_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BR_SINGLE = 3'd0,
    BR_INCR   = 3'd1,
    BR_WRAP4  = 3'd2,
    BR_INCR4  = 3'd3,
    BR_WRAP8  = 3'd4,
    BR_INCR8  = 3'd5,
    BR_WRAP16 = 3'd6,
    BR_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ADDR    = 3'd1,
    ERR_ATTR    = 3'd2,
    ERR_EARLY   = 3'd3,
    ERR_NOBURST = 3'd4,
    ERR_SIZE    = 3'd5,
    ERR_1KB     = 3'd6,
    ERR_ALIGN   = 3'd7
  } err_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Zero means unbounded (INCR).
  function automatic logic [4:0] beats_total(input hburst_e b);
    case (b)
      BR_SINGLE:           return 5'd1;
      BR_WRAP4, BR_INCR4:  return 5'd4;
      BR_WRAP8, BR_INCR8:  return 5'd8;
      BR_WRAP16, BR_INCR16: return 5'd16;
      default:             return 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] beats_log2(input hburst_e b);
    case (b)
      BR_WRAP4, BR_INCR4:   return 3'd2;
      BR_WRAP8, BR_INCR8:   return 3'd3;
      BR_WRAP16, BR_INCR16: return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic is_wrap(input hburst_e b);
    return (b == BR_WRAP4) || (b == BR_WRAP8) || (b == BR_WRAP16);
  endfunction

  function automatic logic is_incr(input hburst_e b);
    return !is_wrap(b) && (b != BR_SINGLE);
  endfunction

endpackage

// File: rtl/ahb_next_addr.sv
// Next expected SEQ address for incrementing and wrapping bursts.
// Latency: combinational. Backpressure: none (pure function of inputs).
module ahb_next_addr
  import ahb_burst_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  hburst_e           burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] mask;
  logic [4:0]        wrap_sh;

  always_comb begin
    step    = ADDR_W'(1) << size;
    sum     = addr + step;
    // Wrap boundary is beats * 2^size, i.e. a shift by size + log2(beats).
    wrap_sh = {2'b00, size} + {2'b00, beats_log2(burst)};
    mask    = (ADDR_W'(1) << wrap_sh) - ADDR_W'(1);
    if (is_wrap(burst)) begin
      next_addr = (addr & ~mask) | (sum & mask);
    end else begin
      next_addr = sum;
    end
  end

endmodule

// File: rtl/ahb_burst_checker.sv
// AHB burst protocol checker; optional 1 KB crossing check under AHB_BURST_1KB_CHECK_EN.
// Latency: error/done pulses and status one cycle after the accepted transfer.
// Backpressure: observe-only; h_ready=0 cycles are ignored.
module ahb_burst_checker
  import ahb_burst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              h_clk,
  input  logic              h_resetn,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [1:0]        h_trans,
  input  logic [2:0]        h_burst,
  input  logic [2:0]        h_size,
  input  logic              h_write,
  input  logic              h_ready,
  output logic              burst_err,
  output logic [2:0]        err_code,
  output logic              burst_active,
  output logic [4:0]        beat_cnt,
  output logic [ADDR_W-1:0] exp_addr,
  output logic              burst_done
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  state_e            state_q, state_d;
  hburst_e           burst_q, burst_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [4:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic              err_d, done_d;
  err_e              code_d;

  htrans_e           trans_in;
  hburst_e           burst_in;
  logic              is_nseq, is_seq, is_busy, is_idle;
  logic [4:0]        total_q;
  logic [ADDR_W-1:0] align_mask;
  logic [ADDR_W-1:0] nxt_addr;
  logic              cross_1kb;

  assign trans_in   = htrans_e'(h_trans);
  assign burst_in   = hburst_e'(h_burst);
  assign is_nseq    = (trans_in == TR_NONSEQ);
  assign is_seq     = (trans_in == TR_SEQ);
  assign is_busy    = (trans_in == TR_BUSY);
  assign is_idle    = (trans_in == TR_IDLE);
  assign total_q    = (burst_q == BR_INCR) ? 5'd0 : beats_total(burst_q);
  assign align_mask = (ADDR_W'(1) << h_size) - ADDR_W'(1);

  // A NONSEQ computes from its own attributes; a SEQ advances with the latched ones.
  ahb_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .addr      (h_addr),
    .size      (is_nseq ? h_size : size_q),
    .burst     (is_nseq ? burst_in : burst_q),
    .next_addr (nxt_addr)
  );

`ifdef AHB_BURST_1KB_CHECK_EN
  logic [ADDR_W-11:0] region_q;

  assign cross_1kb = is_incr(burst_q) && (h_addr[ADDR_W-1:10] != region_q);

  always_ff @(posedge h_clk) begin
    if (!h_resetn) begin
      region_q <= '0;
    end else if (h_ready && is_nseq) begin
      region_q <= h_addr[ADDR_W-1:10];
    end
  end
`else
  assign cross_1kb = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    size_d  = size_q;
    write_d = write_q;
    beat_d  = beat_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
    code_d  = err_e'(err_code);
    done_d  = 1'b0;
    if (h_ready) begin
      err_d = 1'b1;
      if ((is_nseq || is_seq) && (h_size > MAX_SIZE))                        code_d = ERR_SIZE;
      else if ((is_seq || is_busy) && (state_q == ST_IDLE))                  code_d = ERR_NOBURST;
      else if ((is_nseq || is_idle) && (state_q == ST_BURST) && total_q != 0) code_d = ERR_EARLY;
      else if (is_seq && (h_size != size_q || burst_in != burst_q || h_write != write_q))
                                                                             code_d = ERR_ATTR;
      else if (is_seq && (h_addr != exp_q))                                  code_d = ERR_ADDR;
      else if (is_seq && cross_1kb)                                          code_d = ERR_1KB;
      else if (is_nseq && ((h_addr & align_mask) != '0))                     code_d = ERR_ALIGN;
      else err_d = 1'b0;

      if (is_nseq) begin
        burst_d = burst_in;
        size_d  = h_size;
        write_d = h_write;
        beat_d  = 5'd1;
        exp_d   = nxt_addr;
        state_d = (burst_in == BR_SINGLE) ? ST_IDLE : ST_BURST;
      end else if (is_seq && (state_q == ST_BURST)) begin
        beat_d = (beat_q == 5'd31) ? beat_q : beat_q + 5'd1;
        exp_d  = nxt_addr;
        if ((total_q != 5'd0) && (beat_d == total_q)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (is_idle) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge h_clk) begin
    if (!h_resetn) begin
      state_q    <= ST_IDLE;
      burst_q    <= BR_SINGLE;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      beat_q     <= 5'd0;
      exp_q      <= '0;
      burst_err  <= 1'b0;
      err_code   <= 3'd0;
      burst_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
      write_q    <= write_d;
      beat_q     <= beat_d;
      exp_q      <= exp_d;
      burst_err  <= err_d;
      err_code   <= code_d;
      burst_done <= done_d;
    end
  end

  assign burst_active = (state_q == ST_BURST);
  assign beat_cnt     = beat_q;
  assign exp_addr     = exp_q;

endmodule

// File: tb/tb_ahb_burst_checker.sv
// Directed bench for ahb_burst_checker; expected values hand-computed per step.
// Define AHB_BURST_1KB_CHECK_EN for both bench and RTL to exercise the 1 KB check.
module tb_ahb_burst_checker;

  logic        h_clk = 1'b0;
  logic        h_resetn;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic [2:0]  h_burst;
  logic [2:0]  h_size;
  logic        h_write;
  logic        h_ready;
  logic        burst_err;
  logic [2:0]  err_code;
  logic        burst_active;
  logic [4:0]  beat_cnt;
  logic [31:0] exp_addr;
  logic        burst_done;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5;

  ahb_burst_checker #(.ADDR_W(32), .DATA_W(32)) dut (
    .h_clk        (h_clk),
    .h_resetn     (h_resetn),
    .h_addr       (h_addr),
    .h_trans      (h_trans),
    .h_burst      (h_burst),
    .h_size       (h_size),
    .h_write      (h_write),
    .h_ready      (h_ready),
    .burst_err    (burst_err),
    .err_code     (err_code),
    .burst_active (burst_active),
    .beat_cnt     (beat_cnt),
    .exp_addr     (exp_addr),
    .burst_done   (burst_done)
  );

  always #5 h_clk = ~h_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                      input logic [31:0] ad, input logic wr, input logic rdy);
    h_trans = tr;
    h_burst = bu;
    h_size  = sz;
    h_addr  = ad;
    h_write = wr;
    h_ready = rdy;
    @(posedge h_clk);
    #1;
  endtask

  // err/code/active/beat/exp/done in one call
  task automatic chk_all(input string tag, input logic e, input logic [2:0] c, input logic a,
                         input logic [4:0] b, input logic [31:0] x, input logic d);
    chk({tag, ".err"},    32'(burst_err),    32'(e));
    chk({tag, ".code"},   32'(err_code),     32'(c));
    chk({tag, ".active"}, 32'(burst_active), 32'(a));
    chk({tag, ".beat"},   32'(beat_cnt),     32'(b));
    chk({tag, ".exp"},    exp_addr,          x);
    chk({tag, ".done"},   32'(burst_done),   32'(d));
  endtask

  initial begin
    h_resetn = 1'b0;
    step(IDL, SINGLE, 3'd0, 32'h0, 1'b0, 1'b1);
    step(IDL, SINGLE, 3'd0, 32'h0, 1'b0, 1'b0);
    chk_all("reset", 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    h_resetn = 1'b1;

    // WRAP4 word at 0x38: 0x38 -> 0x3C -> 0x30 -> 0x34
    step(NSQ, WRAP4, 3'd2, 32'h38, 1'b0, 1'b1);
    chk_all("wrap_b1", 1'b0, 3'd0, 1'b1, 5'd1, 32'h3C, 1'b0);
    step(SEQ, WRAP4, 3'd2, 32'h3C, 1'b0, 1'b1);
    chk_all("wrap_b2", 1'b0, 3'd0, 1'b1, 5'd2, 32'h30, 1'b0);
    step(SEQ, WRAP4, 3'd2, 32'h30, 1'b0, 1'b1);
    chk_all("wrap_b3", 1'b0, 3'd0, 1'b1, 5'd3, 32'h34, 1'b0);
    step(SEQ, WRAP4, 3'd2, 32'h34, 1'b0, 1'b1);
    chk_all("wrap_b4", 1'b0, 3'd0, 1'b0, 5'd4, 32'h38, 1'b1);
    step(IDL, SINGLE, 3'd0, 32'h0, 1'b0, 1'b1);
    chk("wrap_done_pulse", 32'(burst_done), 32'd0);

    // INCR8 halfword, wrong address on beat 2, tracking continues from received address
    step(NSQ, INCR8, 3'd1, 32'h100, 1'b0, 1'b1);
    chk_all("i8_b1", 1'b0, 3'd0, 1'b1, 5'd1, 32'h102, 1'b0);
    step(SEQ, INCR8, 3'd1, 32'h104, 1'b0, 1'b1);
    chk_all("i8_b2", 1'b1, 3'd1, 1'b1, 5'd2, 32'h106, 1'b0);
    step(SEQ, INCR8, 3'd1, 32'h106, 1'b0, 1'b1);
    chk_all("i8_b3", 1'b0, 3'd1, 1'b1, 5'd3, 32'h108, 1'b0);
    step(IDL, SINGLE, 3'd0, 32'h0, 1'b0, 1'b1);
    chk_all("i8_idle_early", 1'b1, 3'd3, 1'b0, 5'd3, 32'h108, 1'b0);

    // INCR4 interrupted by NONSEQ after beat 2: new burst tracked immediately
    step(NSQ, INCR4, 3'd2, 32'h0, 1'b0, 1'b1);
    step(SEQ, INCR4, 3'd2, 32'h4, 1'b0, 1'b1);
    chk_all("i4_b2", 1'b0, 3'd3, 1'b1, 5'd2, 32'h8, 1'b0);
    step(NSQ, INCR4, 3'd2, 32'h200, 1'b0, 1'b1);
    chk_all("i4_restart", 1'b1, 3'd3, 1'b1, 5'd1, 32'h204, 1'b0);
    step(SEQ, INCR4, 3'd2, 32'h204, 1'b0, 1'b1);
    step(SEQ, INCR4, 3'd2, 32'h208, 1'b0, 1'b1);
    step(SEQ, INCR4, 3'd2, 32'h20C, 1'b0, 1'b1);
    chk_all("i4_new_done", 1'b0, 3'd3, 1'b0, 5'd4, 32'h210, 1'b1);

    // INCR word crossing the 1 KB boundary
    step(NSQ, INCR, 3'd2, 32'h3F8, 1'b0, 1'b1);
    step(SEQ, INCR, 3'd2, 32'h3FC, 1'b0, 1'b1);
    chk_all("incr_b2", 1'b0, 3'd3, 1'b1, 5'd2, 32'h400, 1'b0);
    step(SEQ, INCR, 3'd2, 32'h400, 1'b0, 1'b1);
`ifdef AHB_BURST_1KB_CHECK_EN
    chk_all("incr_1kb", 1'b1, 3'd6, 1'b1, 5'd3, 32'h404, 1'b0);
`else
    chk_all("incr_1kb", 1'b0, 3'd3, 1'b1, 5'd3, 32'h404, 1'b0);
`endif
    step(IDL, SINGLE, 3'd0, 32'h0, 1'b0, 1'b1);
    chk("incr_term.err", 32'(burst_err), 32'd0);
    chk("incr_term.active", 32'(burst_active), 32'd0);

    // Oversize, misaligned NONSEQ, SEQ from IDLE
    step(NSQ, SINGLE, 3'd3, 32'h0, 1'b0, 1'b1);
    chk_all("size", 1'b1, 3'd5, 1'b0, 5'd1, 32'h8, 1'b0);
    step(NSQ, SINGLE, 3'd2, 32'h2, 1'b0, 1'b1);
    chk_all("align", 1'b1, 3'd7, 1'b0, 5'd1, 32'h6, 1'b0);
    step(SEQ, INCR, 3'd2, 32'h10, 1'b0, 1'b1);
    chk_all("seq_idle", 1'b1, 3'd4, 1'b0, 5'd1, 32'h6, 1'b0);

    // Attribute change on SEQ, address still advances
    step(NSQ, INCR4, 3'd2, 32'h80, 1'b0, 1'b1);
    step(SEQ, INCR4, 3'd2, 32'h84, 1'b1, 1'b1);
    chk_all("attr", 1'b1, 3'd2, 1'b1, 5'd2, 32'h88, 1'b0);
    step(IDL, SINGLE, 3'd0, 32'h0, 1'b0, 1'b1);

    // Wait states and BUSY hold, then reset mid-burst
    step(NSQ, INCR4, 3'd2, 32'h40, 1'b0, 1'b1);
    chk_all("hold_b1", 1'b0, 3'd3, 1'b1, 5'd1, 32'h44, 1'b0);
    step(SEQ, INCR4, 3'd2, 32'h44, 1'b0, 1'b0);
    step(SEQ, INCR4, 3'd2, 32'h44, 1'b0, 1'b0);
    step(SEQ, INCR4, 3'd2, 32'h44, 1'b0, 1'b0);
    chk_all("hold_wait", 1'b0, 3'd3, 1'b1, 5'd1, 32'h44, 1'b0);
    step(BSY, INCR4, 3'd2, 32'h44, 1'b0, 1'b1);
    chk_all("hold_busy", 1'b0, 3'd3, 1'b1, 5'd1, 32'h44, 1'b0);
    step(SEQ, INCR4, 3'd2, 32'h44, 1'b0, 1'b1);
    chk_all("hold_b2", 1'b0, 3'd3, 1'b1, 5'd2, 32'h48, 1'b0);
    h_resetn = 1'b0;
    step(SEQ, INCR4, 3'd2, 32'h48, 1'b0, 1'b0);
    chk_all("mid_reset", 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    h_resetn = 1'b1;
    step(SEQ, INCR4, 3'd2, 32'h48, 1'b0, 1'b1);
    chk_all("post_reset_seq", 1'b1, 3'd4, 1'b0, 5'd0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_burst_checker.md
AHB_BURST_CHECKER -- requirements
Module: ahb_burst_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width in bits (32/64/128); max legal h_size = log2(DATA_W/8).
REQ-003 SHALL have ports: h_clk  in  1  clock; h_resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have inputs: h_addr  in  ADDR_W  address; h_trans  in  2  transfer type; h_burst  in  3  burst type; h_size  in  3  size; h_write  in  1  direction; h_ready  in  1  transfer accepted.
REQ-005 SHALL have outputs: burst_err  out  1  one-cycle error pulse; err_code  out  3  cause of last error; burst_active  out  1  burst in progress; beat_cnt  out  5  beats accepted in current burst; exp_addr  out  ADDR_W  expected next SEQ address; burst_done  out  1  one-cycle pulse on final beat of fixed-length burst.

Function
REQ-006 SHALL sample h_addr/h_trans/h_burst/h_size/h_write only on h_clk edges with h_ready=1; h_ready=0 cycles change no state.
REQ-007 SHALL implement FSM IDLE, BURST; IDLE->BURST on accepted NONSEQ with h_burst != SINGLE; BURST->IDLE on final fixed beat, accepted IDLE, or NONSEQ SINGLE.
REQ-008 SHALL latch burst, size, write and set beat_cnt=1 on every accepted NONSEQ; increment beat_cnt on each accepted SEQ; BUSY holds beat_cnt and exp_addr.
REQ-009 SHALL set beat total 4/8/16 for INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16; INCR unbounded (beat_cnt saturates at 31); SINGLE = 1.
REQ-010 SHALL compute exp_addr after each accepted NONSEQ/SEQ: INCR types addr + 2^size; WRAP types with boundary B = beats*2^size: (addr & ~(B-1)) | ((addr + 2^size) & (B-1)); width ADDR_W, carry discarded.
REQ-011 SHALL pulse burst_done the cycle after the accepted beat where beat_cnt reaches the fixed total.
REQ-012 SHALL register burst_err and err_code, valid the cycle after the offending accepted transfer (latency 1); err_code holds until next error or reset.
REQ-013 SHALL detect, highest priority first: 5 h_size > max legal; 4 SEQ or BUSY while IDLE; 3 NONSEQ or IDLE accepted before fixed burst complete; 2 SEQ with h_size, h_burst or h_write differing from latched; 1 SEQ with h_addr != exp_addr; 7 NONSEQ address not aligned to 2^h_size; 6 see REQ-019.
REQ-014 SHALL, on error 3 caused by NONSEQ, report the error and start tracking the new burst in the same cycle.
REQ-015 SHALL treat NONSEQ or IDLE during an INCR burst as legal termination (no error).
REQ-016 SHALL keep tracking after errors 1/2 (advance from received h_addr, keep latched attributes); error 4 leaves FSM in IDLE.

Reset
REQ-017 SHALL, when h_resetn=0 at an h_clk edge, set FSM=IDLE, burst_err=0, err_code=0, burst_active=0, beat_cnt=0, exp_addr=0, burst_done=0, regardless of h_ready.
REQ-018 SHALL abandon any burst in progress on reset with no error; first accepted transfer after reset is evaluated as from IDLE.

Configuration
REQ-019 SHALL, with macro AHB_BURST_1KB_CHECK_EN defined, flag err_code 6 when an accepted SEQ of an INCR-type burst lies in a different 1 KB region (addr[ADDR_W-1:10]) than the burst's NONSEQ; undefined, code 6 SHALL never be produced and the check logic SHALL be absent.

Structure
REQ-020 SHALL place in package ahb_burst_pkg: h_trans and h_burst encodings (IDLE/BUSY/NONSEQ/SEQ; SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16), err_code enumeration, FSM state type, beats-per-burst function.
REQ-021 SHALL implement the REQ-010 address arithmetic in combinational sub-module ahb_next_addr (inputs addr, size, burst; output next address).

Verification
REQ-022 SHALL test WRAP4 word at 0x38: SEQ 0x3C, 0x30, 0x34 -> no burst_err, burst_done pulse after 0x34, FSM IDLE.
REQ-023 SHALL test INCR8 halfword at 0x100 with SEQ 0x104 on beat 2 -> burst_err, err_code=1 one cycle later; beat 3 at 0x106 accepted without error.
REQ-024 SHALL test INCR4 word at 0x0, NONSEQ at 0x200 after beat 2 -> err_code=3, beat_cnt=1, new burst tracked.
REQ-025 SHALL test INCR word at 0x3F8 with SEQ 0x3FC, 0x400 -> err_code=6 with AHB_BURST_1KB_CHECK_EN, no error without it.
REQ-026 SHALL test SEQ with h_ready=0 held 3 cycles then BUSY, then h_ready=1 -> beat_cnt and exp_addr unchanged until accepted SEQ; h_resetn=0 mid-burst -> all outputs 0 next edge.
